instr_sequencer: RTL

//  Fetch/execute control unit for the EV22 core. Fetches 16-bit instruction words {opcode,operand} from program

---
 rtl/instr_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the EV22 core: fetches {opcode,operand} words into IR,
// steps the PC through jumps, BSR/RET, data-memory handshakes and register writeback.
module instr_sequencer #(
  parameter int unsigned PC_W     = 11,
  parameter int unsigned RS_DEPTH = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_rd,
  input  logic            pm_valid,
  input  logic [15:0]     pm_data,
  output logic [7:0]      ir_opcode,
  output logic [7:0]      ir_operand,
  input  logic            dec_mr,
  input  logic            dec_mw,
  output logic            dm_req,
  output logic            dm_we,
  input  logic            dm_ack,
  input  logic            flag_z,
  input  logic            flag_w15,
  input  logic            flag_cy,
  output logic            reg_we,
  output logic            busy,
  output logic            stack_err
);

  localparam int unsigned SP_W  = $clog2(RS_DEPTH + 1);
  localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int unsigned OFF_W = 10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [7:0]       operand_q, operand_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [PC_W-1:0]  stack_q [RS_DEPTH];
  logic             push;
  logic             err_q, err_d;
  logic             dm_we_q, dm_we_d;
  logic             pm_rd_q, dm_req_q, busy_q;

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  jmp_target;
  logic [PC_W-1:0]  bsr_off;
  logic [OFF_W-1:0] bsr_raw;
  logic [PC_W-1:0]  ret_addr;
  logic             jmp_taken;

  // Branch/return target arithmetic shared by the EXEC decode below
  always_comb begin
    pc_inc     = pc_q + PC_W'(1);
    jmp_target = PC_W'({opcode_q[2:0], operand_q});
    bsr_raw    = {opcode_q[1:0], operand_q};
    bsr_off    = PC_W'($signed(bsr_raw));
    ret_addr   = stack_q[IDX_W'(sp_q - SP_W'(1))] + PC_W'(1);
    case (opcode_q[4:3])
      2'b00:   jmp_taken = 1'b1;
      2'b01:   jmp_taken = flag_z;
      2'b10:   jmp_taken = ~flag_w15;
      default: jmp_taken = flag_cy;
    endcase
  end

  // Next-state, PC, stack and writeback strobe decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    sp_d      = sp_q;
    push      = 1'b0;
    err_d     = err_q;
    dm_we_d   = 1'b0;
    reg_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (pm_valid) begin
          opcode_d  = pm_data[15:8];
          operand_d = pm_data[7:0];
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
        if (opcode_q[7:5] == 3'b001) begin
          pc_d = jmp_taken ? jmp_target : pc_inc;
        end else if (opcode_q[7:2] == 6'b000111) begin
          if (sp_q == SP_W'(RS_DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
            pc_d = pc_q + bsr_off;
          end
        end else if (opcode_q == 8'h41) begin
          if (sp_q == '0) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            sp_d = sp_q - SP_W'(1);
            pc_d = ret_addr;
          end
        end else if (dec_mr | dec_mw) begin
          state_d = S_MEM;
          dm_we_d = dec_mw;
          pc_d    = pc_inc;
        end else begin
          reg_we = 1'b1;
          pc_d   = pc_inc;
        end
      end
      S_MEM: begin
        if (dm_ack) begin
          reg_we  = ~dm_we_q;
          state_d = run ? S_FETCH : S_IDLE;
        end else begin
          dm_we_d = dm_we_q;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC, IR, return stack and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_W'(RESET_PC);
      opcode_q  <= '0;
      operand_q <= '0;
      sp_q      <= '0;
      stack_q   <= '{default: '0};
      err_q     <= 1'b0;
      dm_we_q   <= 1'b0;
      pm_rd_q   <= 1'b0;
      dm_req_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      dm_we_q   <= dm_we_d;
      pm_rd_q   <= (state_d == S_FETCH);
      dm_req_q  <= (state_d == S_MEM);
      busy_q    <= (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_MEM);
      if (push) stack_q[IDX_W'(sp_q)] <= pc_q;
    end
  end

  assign pm_addr    = pc_q;
  assign pm_rd      = pm_rd_q;
  assign ir_opcode  = opcode_q;
  assign ir_operand = operand_q;
  assign dm_req     = dm_req_q;
  assign dm_we      = dm_we_q;
  assign busy       = busy_q;
  assign stack_err  = err_q;

endmodule
